display_cmd_parser: RTL and testbench
=====================================

# display_cmd_parser

Byte-level command decoder sitting directly downstream of `spi_slave` in the display controller. Consumes the `data`/`valid`/`sot`/`eot` byte stream, interprets the first byte of each SPI transaction as a command, and turns the payload into framebuffer writes, a brightness register update or a buffer-swap pulse. Its outputs drive the framebuffer RAM write port and the display scan logic.

## Interface
- `ADDR_WIDTH`, 11, framebuffer address width; the address space is 2**ADDR_WIDTH bytes.
- `BRIGHT_RESET`, 8'h80, brightness value after reset.

- `clk` in 1: system clock, the same clock as `spi_slave`.
- `rst` in 1: asynchronous reset, active-high.
- `data` in 8: received byte from `spi_slave`.
- `valid` in 1: one-cycle strobe; `data` is valid on this cycle.
- `sot` in 1: high together with `valid` on the first byte of a transaction.
- `eot` in 1: one-cycle pulse after SS release.
- `fb_addr` out ADDR_WIDTH: framebuffer write address.
- `fb_wdata` out 8: framebuffer write data.
- `fb_we` out 1: framebuffer write enable, one cycle per byte.
- `brightness` out 8: current brightness register.
- `swap` out 1: one-cycle buffer-swap pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `err_count` out 8: count of rejected commands. Present only with the macro in Configuration.

## Operation
- Commands:
  - 0x01 WRITE: addr_hi, addr_lo, then N pixel bytes.
  - 0x02 BRIGHT: one value byte.
  - 0x03 SWAP: no payload.
  - Any other value is unknown.
- States: IDLE, ADDR_HI, ADDR_LO, PIXELS, BRIGHT, SWAP_ARMED, DISCARD.
- `valid & sot` in any state decodes `data` as a command (resynchronisation). The command goes to:
  - 0x01: ADDR_HI.
  - 0x02: BRIGHT.
  - 0x03: SWAP_ARMED.
  - Unknown: DISCARD.
- `valid` without `sot` in IDLE goes to DISCARD.
- WRITE sequence:
  - ADDR_HI latches the high byte, then goes to ADDR_LO.
  - ADDR_LO forms the 16-bit address, keeps the low ADDR_WIDTH bits, then goes to PIXELS.
  - Each byte in PIXELS writes at the current address, then increments it.
  - The address wraps from 2**ADDR_WIDTH-1 to 0.
- BRIGHT: the first payload byte loads `brightness`, then the state goes to DISCARD. Later bytes are ignored.
- SWAP_ARMED: `swap` pulses only when `eot` arrives. Any payload byte cancels the swap and goes to DISCARD.
- DISCARD ignores all bytes until `eot` or a new `sot`.
- `eot` returns the FSM to IDLE from any state.
- Same-cycle `valid` and `eot`: the byte is processed first, then the next state is IDLE.
- A transaction truncated before its payload is complete has no side effect. Writes already issued stand.

## Timing
- Reset values: `fb_addr`=0, `fb_wdata`=0, `fb_we`=0, `brightness`=BRIGHT_RESET, `swap`=0, `busy`=0, `err_count`=0.
- State is lost on reset mid-transaction. The FSM goes to IDLE with no write in flight.
- `fb_we`, `fb_addr` and `fb_wdata` are registered and assert on the cycle after the pixel `valid` (latency 1).
- `brightness` updates on the cycle after the BRIGHT payload `valid`.
- `swap` is high for the single cycle after `eot`.
- Back-to-back `valid` on consecutive cycles is sustained, one write per cycle.

## Configuration
- `DISPLAY_CMD_PARSER_ERR_COUNT_EN` defined:
  - `err_count` port exists.
  - It increments once per unknown command byte, once per stray non-`sot` byte in IDLE, and once per cancelled SWAP.
  - It saturates at 8'hFF.
- Undefined: the port and counter are removed. Behaviour is otherwise identical.

## Structure
- Shared package `display_pkg`:
  - Command codes CMD_WRITE=8'h01, CMD_BRIGHT=8'h02, CMD_SWAP=8'h03.
  - State encoding localparams.
- No sub-module. Single FSM plus an address counter.

## Test plan
- SOT 0x01, 0x00, 0x10, AA, BB, CC, EOT -> writes (0x010,AA), (0x011,BB), (0x012,CC), each one cycle after its `valid`; `busy` low after `eot`.
- WRITE at addr 0x07FF with ADDR_WIDTH=11, bytes 11, 22 -> writes (0x7FF,11) then (0x000,22).
- SOT 0x02, 0x40, 0x55, EOT -> `brightness`=0x40; 0x55 ignored. SOT 0x02, EOT -> `brightness` unchanged.
- SOT 0x03, EOT -> one-cycle `swap` after `eot`. SOT 0x03, 0x00, EOT -> no `swap`; `err_count`=1 with the macro.
- SOT 0x7E, 11, 22, EOT -> no writes; `err_count` +1. Then new SOT 0x01 mid-PIXELS -> re-decoded, old address abandoned.
- `rst` pulsed during PIXELS -> all outputs return to reset values; the next SOT 0x01 transaction writes correctly.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display controller command path: command codes and parser states.
package display_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_SWAP   = 8'h03;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR_HI    = 3'd1;
    localparam logic [2:0] ST_ADDR_LO    = 3'd2;
    localparam logic [2:0] ST_PIXELS     = 3'd3;
    localparam logic [2:0] ST_BRIGHT     = 3'd4;
    localparam logic [2:0] ST_SWAP_ARMED = 3'd5;
    localparam logic [2:0] ST_DISCARD    = 3'd6;

    typedef enum logic [2:0] {
        StIdle      = ST_IDLE,
        StAddrHi    = ST_ADDR_HI,
        StAddrLo    = ST_ADDR_LO,
        StPixels    = ST_PIXELS,
        StBright    = ST_BRIGHT,
        StSwapArmed = ST_SWAP_ARMED,
        StDiscard   = ST_DISCARD
    } state_e;

endpackage

// File: rtl/display_cmd_parser.sv
// Decodes the SPI byte stream into framebuffer writes, brightness updates and swap pulses.
// Define DISPLAY_CMD_PARSER_ERR_COUNT_EN to add the saturating rejected-command counter.
module display_cmd_parser
    import display_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter logic [7:0]  BRIGHT_RESET = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data,
    input  logic                  valid,
    input  logic                  sot,
    input  logic                  eot,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [7:0]            fb_wdata,
    output logic                  fb_we,
    output logic [7:0]            brightness,
    output logic                  swap,
    output logic                  busy
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]            fb_wdata_q, fb_wdata_d;
    logic                  fb_we_q, fb_we_d;
    logic [7:0]            bright_q, bright_d;
    logic                  swap_q, swap_d;
    logic                  err_inc;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        fb_we_d    = 1'b0;
        bright_d   = bright_q;
        swap_d     = 1'b0;
        err_inc    = 1'b0;

        if (valid && sot) begin
            // A start-of-transaction byte always re-decodes, whatever was in progress.
            unique case (data)
                CMD_WRITE:  state_d = StAddrHi;
                CMD_BRIGHT: state_d = StBright;
                CMD_SWAP:   state_d = StSwapArmed;
                default: begin
                    state_d = StDiscard;
                    err_inc = 1'b1;
                end
            endcase
        end else if (valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StDiscard;
                    err_inc = 1'b1;
                end
                StAddrHi: begin
                    hi_d    = data;
                    state_d = StAddrLo;
                end
                StAddrLo: begin
                    addr_d  = ADDR_WIDTH'({hi_q, data});
                    state_d = StPixels;
                end
                StPixels: begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = addr_q;
                    fb_wdata_d = data;
                    addr_d     = addr_q + 1'b1;
                end
                StBright: begin
                    bright_d = data;
                    state_d  = StDiscard;
                end
                StSwapArmed: begin
                    state_d = StDiscard;
                    err_inc = 1'b1;
                end
                default: ;
            endcase
        end else if (eot && state_q == StSwapArmed) begin
            swap_d = 1'b1;
        end

        // Any byte on the same cycle has already been handled above.
        if (eot) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            hi_q       <= '0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            fb_we_q    <= 1'b0;
            bright_q   <= BRIGHT_RESET;
            swap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            fb_we_q    <= fb_we_d;
            bright_q   <= bright_d;
            swap_q     <= swap_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign fb_we      = fb_we_q;
    assign brightness = bright_q;
    assign swap       = swap_q;
    assign busy       = (state_q != StIdle);

`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
`endif

endmodule

// File: tb/tb_display_cmd_parser.sv
// Self-checking bench for display_cmd_parser: directed vector table, reset/corner sequences,
// and random transactions checked against a transaction-level model.
module tb_display_cmd_parser;

    localparam int unsigned AW     = 11;
    localparam int unsigned ASZ    = 1 << AW;
    localparam int          NTRANS = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data;
    logic          valid, sot, eot;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic          fb_we;
    logic [7:0]    brightness;
    logic          swap, busy;
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    display_cmd_parser #(
        .ADDR_WIDTH   (AW),
        .BRIGHT_RESET (8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .valid      (valid),
        .sot        (sot),
        .eot        (eot),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_we      (fb_we),
        .brightness (brightness),
        .swap       (swap),
        .busy       (busy)
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic          v, s, e;
        logic [7:0]    d;
        logic          we;
        logic [AW-1:0] a;
        logic [7:0]    wd;
        logic [7:0]    br;
        logic          sw, bz;
        logic [7:0]    er;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    vec_t tbl[$];
    wr_t  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
        valid = v;
        sot   = s;
        eot   = e;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sot   = 1'b0;
        eot   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    function automatic vec_t tv(input logic v, input logic s, input logic e, input logic [7:0] d,
                                input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                                input logic [7:0] br, input logic sw, input logic bz,
                                input logic [7:0] er);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.d = d; r.we = we; r.a = a; r.wd = wd;
        r.br = br; r.sw = sw; r.bz = bz; r.er = er;
        return r;
    endfunction

    // Random-phase monitor: every write must match the model's next predicted write.
    bit chk_en = 1'b0;
    int seen_swaps = 0;
    wr_t mw;

    always @(negedge clk) begin
        if (chk_en) begin
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    mw = exp_q.pop_front();
                    check("rnd_wr_addr", 32'(fb_addr), 32'(mw.addr));
                    check("rnd_wr_data", 32'(fb_wdata), 32'(mw.data));
                end
            end
            if (swap) seen_swaps++;
        end
    end

    logic [7:0] cmd;
    logic [7:0] pay [8];
    int         len, nstray, base, m_err, m_bright, exp_swaps, sel;
    bit         term, merge, open, exp_sw;
    wr_t        w;

    initial begin
        valid = 1'b0; sot = 1'b0; eot = 1'b0; data = 8'h00;
        do_reset();

        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_brightness", 32'(brightness), 32'h80);
        check("rst_swap", 32'(swap), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
        check("rst_err_count", 32'(err_count), 0);
`endif

        // v s e data | we addr wdata | bright swap busy err
        tbl.push_back(tv(1, 1, 0, 8'h01, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h10, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'hAA, 1, 11'h010, 8'hAA, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'hBB, 1, 11'h011, 8'hBB, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'hCC, 1, 11'h012, 8'hCC, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h80, 0, 0, 8'd0));
        tbl.push_back(tv(0, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h80, 0, 0, 8'd0));
        // address wrap at the top of the framebuffer
        tbl.push_back(tv(1, 1, 0, 8'h01, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h07, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'hFF, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h11, 1, 11'h7FF, 8'h11, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h22, 1, 11'h000, 8'h22, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h80, 0, 0, 8'd0));
        // brightness, extra byte ignored, then empty BRIGHT
        tbl.push_back(tv(1, 1, 0, 8'h02, 0, 11'h000, 8'h00, 8'h80, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h40, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h55, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd0));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd0));
        tbl.push_back(tv(1, 1, 0, 8'h02, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd0));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd0));
        // swap, then cancelled swap
        tbl.push_back(tv(1, 1, 0, 8'h03, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd0));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 1, 0, 8'd0));
        tbl.push_back(tv(0, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd0));
        tbl.push_back(tv(1, 1, 0, 8'h03, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd0));
        tbl.push_back(tv(1, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd1));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd1));
        // unknown command swallows its payload
        tbl.push_back(tv(1, 1, 0, 8'h7E, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h11, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h22, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd2));
        // resync with a new WRITE in the middle of PIXELS
        tbl.push_back(tv(1, 1, 0, 8'h01, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h20, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h5A, 1, 11'h020, 8'h5A, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 1, 0, 8'h01, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h03, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h77, 1, 11'h300, 8'h77, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h40, 0, 0, 8'd2));
        // byte and eot on the same cycle, stray byte in idle, cancel-with-eot
        tbl.push_back(tv(1, 1, 0, 8'h02, 0, 11'h000, 8'h00, 8'h40, 0, 1, 8'd2));
        tbl.push_back(tv(1, 0, 1, 8'h99, 0, 11'h000, 8'h00, 8'h99, 0, 0, 8'd2));
        tbl.push_back(tv(1, 0, 0, 8'h12, 0, 11'h000, 8'h00, 8'h99, 0, 1, 8'd3));
        tbl.push_back(tv(0, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h99, 0, 0, 8'd3));
        tbl.push_back(tv(1, 1, 0, 8'h03, 0, 11'h000, 8'h00, 8'h99, 0, 1, 8'd3));
        tbl.push_back(tv(1, 0, 1, 8'h00, 0, 11'h000, 8'h00, 8'h99, 0, 0, 8'd4));
        tbl.push_back(tv(0, 0, 0, 8'h00, 0, 11'h000, 8'h00, 8'h99, 0, 0, 8'd4));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
            check($sformatf("vec%0d_fb_we", i), 32'(fb_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                check($sformatf("vec%0d_fb_addr", i), 32'(fb_addr), 32'(tbl[i].a));
                check($sformatf("vec%0d_fb_wdata", i), 32'(fb_wdata), 32'(tbl[i].wd));
            end
            check($sformatf("vec%0d_brightness", i), 32'(brightness), 32'(tbl[i].br));
            check($sformatf("vec%0d_swap", i), 32'(swap), 32'(tbl[i].sw));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
            check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(tbl[i].er));
`endif
        end

        // Asynchronous reset in the middle of PIXELS.
        step(1'b1, 1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h40);
        step(1'b1, 1'b0, 1'b0, 8'h11);
        check("pre_rst_write", 32'(fb_we), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_fb_we", 32'(fb_we), 0);
        check("mid_rst_fb_addr", 32'(fb_addr), 0);
        check("mid_rst_fb_wdata", 32'(fb_wdata), 0);
        check("mid_rst_brightness", 32'(brightness), 32'h80);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_swap", 32'(swap), 0);
        #3;
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h22);
        check("post_rst_no_write", 32'(fb_we), 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h05);
        step(1'b1, 1'b0, 1'b0, 8'h33);
        check("post_rst_we", 32'(fb_we), 1);
        check("post_rst_addr", 32'(fb_addr), 32'h005);
        check("post_rst_data", 32'(fb_wdata), 32'h33);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("post_rst_idle", 32'(busy), 0);

`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h05);
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check("err_saturate", 32'(err_count), 32'hFF);
`endif

        // Random transactions against the transaction-level model.
        do_reset();
        m_err = 0; m_bright = 32'h80; exp_swaps = 0; open = 1'b0;
        chk_en = 1'b1;
        for (int t = 0; t < NTRANS; t++) begin
            if (!open && $urandom_range(0, 7) == 0) begin
                nstray = int'($urandom_range(1, 3));
                for (int i = 0; i < nstray; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
                step(1'b0, 1'b0, 1'b1, 8'h00);
                if (m_err < 255) m_err++;
            end
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       cmd = 8'h01;
                1:       cmd = 8'h02;
                2:       cmd = 8'h03;
                default: cmd = 8'($urandom_range(4, 255));
            endcase
            len = int'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
            term  = (t == NTRANS - 1) || ($urandom_range(0, 5) != 0);
            merge = term && (len > 0) && ($urandom_range(0, 2) == 0);
            exp_sw = 1'b0;
            case (cmd)
                8'h01: if (len >= 2) begin
                    base = (int'(pay[0]) * 256 + int'(pay[1])) % ASZ;
                    for (int i = 2; i < len; i++) begin
                        w.addr = AW'((base + i - 2) % ASZ);
                        w.data = pay[i];
                        exp_q.push_back(w);
                    end
                end
                8'h02: if (len >= 1) m_bright = int'(pay[0]);
                8'h03: begin
                    if (len > 0) begin
                        if (m_err < 255) m_err++;
                    end else if (term) begin
                        exp_sw = 1'b1;
                    end
                end
                default: if (m_err < 255) m_err++;
            endcase

            step(1'b1, 1'b1, 1'b0, cmd);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 8'h00);
                step(1'b1, 1'b0, merge && (i == len - 1), pay[i]);
            end
            if (term && !merge) begin
                if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0, 8'h00);
                step(1'b0, 1'b0, 1'b1, 8'h00);
            end
            if (term) begin
                check("rnd_swap_at_eot", 32'(swap), 32'(exp_sw));
                check("rnd_brightness", 32'(brightness), 32'(m_bright));
                check("rnd_busy_after_eot", 32'(busy), 0);
                exp_swaps += int'(exp_sw);
            end
            open = !term;
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b0;
        check("rnd_writes_outstanding", 32'(exp_q.size()), 0);
        check("rnd_swap_count", 32'(seen_swaps), 32'(exp_swaps));
        check("rnd_final_brightness", 32'(brightness), 32'(m_bright));
`ifdef DISPLAY_CMD_PARSER_ERR_COUNT_EN
        check("rnd_err_count", 32'(err_count), 32'(m_err));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
